// File: rtl/rx_intf_m_axis_if.sv
// AXI-Stream beat bundle between the RX stream master and the PS DMA.
interface rx_intf_m_axis_if #(
   parameter int C_M_AXIS_TDATA_WIDTH = 64
);
   logic                                M_AXIS_TVALID;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA;
   logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB;
   logic                                M_AXIS_TLAST;
   logic                                M_AXIS_TREADY;

   modport master (
      output M_AXIS_TVALID,
      output M_AXIS_TDATA,
      output M_AXIS_TSTRB,
      output M_AXIS_TLAST,
      input  M_AXIS_TREADY
   );

   modport slave (
      input  M_AXIS_TVALID,
      input  M_AXIS_TDATA,
      input  M_AXIS_TSTRB,
      input  M_AXIS_TLAST,
      output M_AXIS_TREADY
   );
endinterface

// File: rtl/rx_intf_m_axis.sv
// RX stream master: buffers accelerator words in a FWFT FIFO and streams one
// armed DMA transfer at a time, optionally led by a TSF header beat.
module rx_intf_m_axis #(
   parameter int C_M_AXIS_TDATA_WIDTH   = 64,
   parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
   parameter int FIFO_AW                = 6,
   parameter int TSF_TIMER_WIDTH        = 64
) (
   input  logic                              M_AXIS_ACLK,
   input  logic                              M_AXIS_ARESETN,
   rx_intf_m_axis_if.master                  m_axis,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   DATA_FROM_ACC,
   input  logic                              DATA_FROM_ACC_VALID,
   output logic                              FULL_TO_ACC,
   output logic [FIFO_AW:0]                  data_count,
   input  logic                              start_1trans,
   input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
   input  logic                              hdr_en,
   input  logic [TSF_TIMER_WIDTH-1:0]        tsf_runtime_val,
   output logic                              busy,
   output logic                              trans_done,
   output logic                              overflow
);
   typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2} state_e;

   localparam int                                DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]                  CNT_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]                  CNT_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0]                PTR_ONE  = FIFO_AW'(1);
   localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] BEAT_ONE = MAX_BIT_NUM_DMA_SYMBOL'(1);

   state_e                              state_q, state_d;
   logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   len_q, len_d;
   logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_cnt_q, beat_cnt_d;
   logic [TSF_TIMER_WIDTH-1:0]          tsf_q, tsf_d;
   logic [FIFO_AW-1:0]                  wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]                  rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]                    cnt_q, cnt_d;
   logic                                trans_done_q, trans_done_d;
   logic                                overflow_q, overflow_d;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]     mem_q [DEPTH];

   logic                                full_s, empty_s, wr_en_s, pop_s;
   logic                                tvalid_s, tlast_s;
   logic [C_M_AXIS_TDATA_WIDTH-1:0]     tdata_s;

   // Full is judged before any same-cycle pop, so a write into a full FIFO is dropped.
   assign full_s  = (cnt_q == CNT_FULL);
   assign empty_s = (cnt_q == {(FIFO_AW+1){1'b0}});
   assign wr_en_s = DATA_FROM_ACC_VALID && !full_s;
   assign pop_s   = (state_q == SEND) && tvalid_s && m_axis.M_AXIS_TREADY;

   // FIFO storage array.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= DATA_FROM_ACC;
      end
   end

   // Beat presentation: all stream outputs derive from registered state only.
   always_comb begin
      tvalid_s = 1'b0;
      tlast_s  = 1'b0;
      tdata_s  = {C_M_AXIS_TDATA_WIDTH{1'b0}};
      case (state_q)
         HDR: begin
            tvalid_s = 1'b1;
            tdata_s  = C_M_AXIS_TDATA_WIDTH'(tsf_q);
         end
         SEND: begin
            if (!empty_s) begin
               tvalid_s = 1'b1;
               tdata_s  = mem_q[rd_ptr_q];
               tlast_s  = (beat_cnt_q == len_q);
            end else begin
               tvalid_s = 1'b0;
            end
         end
         default: begin
            tvalid_s = 1'b0;
         end
      endcase
   end

   // Next-state, transfer bookkeeping and FIFO pointer updates.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      tsf_d        = tsf_q;
      trans_done_d = 1'b0;
      overflow_d   = overflow_q;
      wr_ptr_d     = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d     = pop_s   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({wr_en_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start_1trans) begin
               len_d      = num_dma_symbol;
               tsf_d      = tsf_runtime_val;
               beat_cnt_d = {MAX_BIT_NUM_DMA_SYMBOL{1'b0}};
               overflow_d = 1'b0;
               state_d    = hdr_en ? HDR : SEND;
            end else begin
               state_d    = IDLE;
            end
         end
         HDR: begin
            if (m_axis.M_AXIS_TREADY) begin
               state_d = SEND;
            end else begin
               state_d = HDR;
            end
         end
         SEND: begin
            // The final beat leaves beat_cnt at len so it can never wrap.
            if (pop_s && tlast_s) begin
               state_d      = IDLE;
               trans_done_d = 1'b1;
            end else if (pop_s) begin
               beat_cnt_d   = beat_cnt_q + BEAT_ONE;
            end else begin
               state_d      = SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (DATA_FROM_ACC_VALID && full_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_d;
      end
   end

   // State and control registers.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         state_q      <= IDLE;
         len_q        <= {MAX_BIT_NUM_DMA_SYMBOL{1'b0}};
         beat_cnt_q   <= {MAX_BIT_NUM_DMA_SYMBOL{1'b0}};
         tsf_q        <= {TSF_TIMER_WIDTH{1'b0}};
         wr_ptr_q     <= {FIFO_AW{1'b0}};
         rd_ptr_q     <= {FIFO_AW{1'b0}};
         cnt_q        <= {(FIFO_AW+1){1'b0}};
         trans_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         tsf_q        <= tsf_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         trans_done_q <= trans_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign m_axis.M_AXIS_TVALID = tvalid_s;
   assign m_axis.M_AXIS_TDATA  = tdata_s;
   assign m_axis.M_AXIS_TLAST  = tlast_s;
   assign m_axis.M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
   assign FULL_TO_ACC          = full_s;
   assign data_count           = cnt_q;
   assign busy                 = (state_q != IDLE);
   assign trans_done           = trans_done_q;
   assign overflow             = overflow_q;
endmodule

// File: tb/tb_rx_intf_m_axis.sv
// Scoreboard bench for rx_intf_m_axis: a queue model of FIFO and transfers
// predicts every beat; a negedge monitor compares outputs against it.
module tb_rx_intf_m_axis;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] din = 64'd0;
   logic        din_vld = 1'b0;
   logic        full;
   logic [6:0]  data_count;
   logic        start = 1'b0;
   logic [13:0] num = 14'd0;
   logic        hdr_en = 1'b0;
   logic [63:0] tsf = 64'h1000_0000;
   logic        busy, trans_done, overflow;

   rx_intf_m_axis_if #(.C_M_AXIS_TDATA_WIDTH(64)) axis_if ();

   rx_intf_m_axis #(
      .C_M_AXIS_TDATA_WIDTH(64), .MAX_BIT_NUM_DMA_SYMBOL(14),
      .FIFO_AW(6), .TSF_TIMER_WIDTH(64)
   ) dut (
      .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .m_axis(axis_if),
      .DATA_FROM_ACC(din), .DATA_FROM_ACC_VALID(din_vld), .FULL_TO_ACC(full),
      .data_count(data_count), .start_1trans(start), .num_dma_symbol(num),
      .hdr_en(hdr_en), .tsf_runtime_val(tsf), .busy(busy),
      .trans_done(trans_done), .overflow(overflow)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          is_hdr;
      logic [63:0] tsf;
      bit          last;
   } beat_t;

   beat_t       exp_q[$];
   logic [63:0] model_fifo[$];
   logic [63:0] pend[$];
   bit          model_busy = 1'b0;
   bit          exp_done = 1'b0;
   bit          exp_ovf = 1'b0;
   bit          prev_stall = 1'b0;
   logic [63:0] prev_data = 64'd0;
   logic        prev_last = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_beats = 0;
   int          cyc = 0;
   int          wr_period = 1;
   bit          rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor/scoreboard: check the present cycle, then predict the next edge.
   initial begin : monitor
      bit    ev, el, acc, drop;
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_tvalid", axis_if.M_AXIS_TVALID, 64'd0);
            check("rst_tlast", axis_if.M_AXIS_TLAST, 64'd0);
            check("rst_tdata", axis_if.M_AXIS_TDATA, 64'd0);
            check("rst_busy", busy, 64'd0);
            check("rst_trans_done", trans_done, 64'd0);
            check("rst_overflow", overflow, 64'd0);
            check("rst_data_count", data_count, 64'd0);
            check("rst_full", full, 64'd0);
            exp_q.delete();
            model_fifo.delete();
            model_busy = 1'b0;
            exp_done   = 1'b0;
            exp_ovf    = 1'b0;
            prev_stall = 1'b0;
         end else begin
            ev = model_busy && (exp_q.size() > 0) &&
                 (exp_q[0].is_hdr || (model_fifo.size() > 0));
            el = ev && !exp_q[0].is_hdr && exp_q[0].last;
            check("tvalid", axis_if.M_AXIS_TVALID, ev);
            if (axis_if.M_AXIS_TVALID) check("tlast", axis_if.M_AXIS_TLAST, el);
            else check("tdata_idle_zero", axis_if.M_AXIS_TDATA, 64'd0);
            check("tstrb", axis_if.M_AXIS_TSTRB, 64'hFF);
            check("busy", busy, model_busy);
            check("trans_done", trans_done, exp_done);
            check("data_count", data_count, model_fifo.size());
            check("full", full, model_fifo.size() == DEPTH);
            check("overflow", overflow, exp_ovf);
            if (prev_stall) begin
               check("hold_tvalid", axis_if.M_AXIS_TVALID, 64'd1);
               check("hold_tdata", axis_if.M_AXIS_TDATA, prev_data);
               check("hold_tlast", axis_if.M_AXIS_TLAST, prev_last);
            end
            prev_stall = axis_if.M_AXIS_TVALID && !axis_if.M_AXIS_TREADY;
            prev_data  = axis_if.M_AXIS_TDATA;
            prev_last  = axis_if.M_AXIS_TLAST;
            exp_done   = 1'b0;

            // Effects of the coming rising edge, in the order the spec defines.
            acc  = din_vld && (model_fifo.size() < DEPTH);
            drop = din_vld && !acc;
            if (start && !model_busy) begin
               if (hdr_en) exp_q.push_back('{is_hdr: 1'b1, tsf: tsf, last: 1'b0});
               for (int i = 0; i <= int'(num); i++)
                  exp_q.push_back('{is_hdr: 1'b0, tsf: 64'd0, last: (i == int'(num))});
               model_busy = 1'b1;
               exp_ovf    = 1'b0;
            end
            if (axis_if.M_AXIS_TVALID && axis_if.M_AXIS_TREADY) begin
               if (exp_q.size() == 0 || (!exp_q[0].is_hdr && model_fifo.size() == 0)) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got tdata %h, required no beat", axis_if.M_AXIS_TDATA);
               end else begin
                  e = exp_q.pop_front();
                  n_beats++;
                  if (e.is_hdr) begin
                     check("hdr_beat_data", axis_if.M_AXIS_TDATA, e.tsf);
                  end else begin
                     check("data_beat", axis_if.M_AXIS_TDATA, model_fifo.pop_front());
                  end
                  if (e.last) begin
                     model_busy = 1'b0;
                     exp_done   = 1'b1;
                  end
               end
            end
            if (acc) model_fifo.push_back(din);
            if (drop) exp_ovf = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      tsf   = tsf + 64'd1;
      start = 1'b0;
      if (rand_ready) axis_if.M_AXIS_TREADY = 1'($urandom_range(0, 1));
      if (rst_n && pend.size() > 0 && (cyc % wr_period == 0)) begin
         din_vld = 1'b1;
         din     = pend.pop_front();
      end else begin
         din_vld = 1'b0;
         din     = {$urandom, $urandom};
      end
   endtask

   task automatic flush();
      int n = 0;
      while (pend.size() > 0 && n < 1000) begin
         tick();
         n++;
      end
      tick();
   endtask

   task automatic do_start(input int len, input bit h);
      start  = 1'b1;
      num    = 14'(len);
      hdr_en = h;
      tick();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((model_busy || pend.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (model_busy || pend.size() != 0) begin
         n_fail++;
         $display("FAIL wait_done: transfer still open after %0d cycles, required completion", budget);
      end
      tick();
   endtask

   initial begin : stimulus
      int base, n, len;
      bit h;
      axis_if.M_AXIS_TREADY = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Basic: four preloaded words, no header.
      for (int i = 1; i <= 4; i++) pend.push_back(64'(i));
      flush();
      do_start(3, 1'b0);
      wait_done(50);
      check("basic_count_after", data_count, 64'd0);

      // Header beat from the TSF latched at start.
      pend.push_back(64'h55);
      flush();
      tsf = 64'hABCD;
      do_start(0, 1'b1);
      wait_done(50);

      // Backpressure with trickling writes.
      rand_ready = 1'b1;
      wr_period  = 3;
      for (int i = 0; i < 8; i++) pend.push_back({$urandom, $urandom});
      do_start(7, 1'b0);
      wait_done(300);
      rand_ready = 1'b0;
      axis_if.M_AXIS_TREADY = 1'b1;
      wr_period  = 1;

      // Overflow: 65 writes with nothing armed.
      axis_if.M_AXIS_TREADY = 1'b0;
      for (int i = 0; i < 65; i++) pend.push_back(64'h1000 + 64'(i));
      flush();
      check("ovf_full", full, 64'd1);
      check("ovf_flag", overflow, 64'd1);
      check("ovf_count", data_count, 64'd64);
      axis_if.M_AXIS_TREADY = 1'b1;
      do_start(63, 1'b0);
      check("ovf_cleared_on_start", overflow, 64'd0);
      wait_done(200);
      check("ovf_drained", data_count, 64'd0);

      // Start pulses during SEND are ignored.
      for (int i = 0; i < 6; i++) pend.push_back(64'h2000 + 64'(i));
      flush();
      do_start(5, 1'b0);
      tick();
      do_start(1, 1'b1);
      wait_done(50);

      // Reset after two of eight beats.
      axis_if.M_AXIS_TREADY = 1'b0;
      for (int i = 0; i < 8; i++) pend.push_back(64'h3000 + 64'(i));
      flush();
      axis_if.M_AXIS_TREADY = 1'b1;
      do_start(7, 1'b0);
      base = n_beats;
      n = 0;
      while (n_beats < base + 2 && n < 50) begin
         tick();
         n++;
      end
      rst_n = 1'b0;
      #1;
      check("midrst_tvalid", axis_if.M_AXIS_TVALID, 64'd0);
      check("midrst_busy", busy, 64'd0);
      check("midrst_count", data_count, 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      pend.push_back(64'h4444);
      pend.push_back(64'h5555);
      flush();
      do_start(1, 1'b0);
      wait_done(50);

      // Randomized transfers.
      for (int t = 0; t < 6; t++) begin
         len        = int'($urandom_range(0, 9));
         h          = 1'($urandom_range(0, 1));
         rand_ready = 1'b1;
         wr_period  = int'($urandom_range(1, 3));
         for (int i = 0; i <= len; i++) pend.push_back({$urandom, $urandom});
         if ($urandom_range(0, 1) == 1) flush();
         do_start(len, h);
         wait_done(500);
      end
      rand_ready = 1'b0;
      axis_if.M_AXIS_TREADY = 1'b1;
      tick();
      check("end_exp_queue_empty", exp_q.size(), 64'd0);
      check("end_count", data_count, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end
endmodule

// File: doc/rx_intf_m_axis.md
# rx_intf_m_axis

AXI-Stream master that returns received baseband/packet words to the PS DMA, the mirror of the TX-side stream slave. The receive accelerator pushes 64-bit words into an internal first-word-fall-through FIFO. Software arms one DMA transfer at a time with a length, and the block streams exactly that many words to the DMA with TLAST on the final beat. An optional TSF timestamp header word can be prepended to each transfer.

## Interface
Parameters:
- C_M_AXIS_TDATA_WIDTH, 64, stream data width (fixed at 64 in this design)
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of the length field
- FIFO_AW, 6, FIFO address width (depth = 2^FIFO_AW)
- TSF_TIMER_WIDTH, 64, TSF width

Ports:
- M_AXIS_ACLK  in  1  single clock for the whole block
- M_AXIS_ARESETN  in  1  reset; asynchronous, active-low
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  64  beat data; 0 whenever TVALID=0
- M_AXIS_TSTRB  out  8  constant 8'hFF
- M_AXIS_TLAST  out  1  last beat of the transfer
- M_AXIS_TREADY  in  1  DMA ready
- DATA_FROM_ACC  in  64  word from the RX accelerator
- DATA_FROM_ACC_VALID  in  1  write strobe into the FIFO
- FULL_TO_ACC  out  1  FIFO full
- data_count  out  FIFO_AW+1  FIFO occupancy
- start_1trans  in  1  one-cycle pulse that arms a transfer
- num_dma_symbol  in  MAX_BIT_NUM_DMA_SYMBOL  data beats minus 1
- hdr_en  in  1  prepend a TSF header beat
- tsf_runtime_val  in  64  free-running TSF
- busy  out  1  transfer in progress
- trans_done  out  1  one-cycle pulse after the last beat
- overflow  out  1  sticky flag: a write was dropped

## Operation
- FIFO:
  - A write is accepted iff DATA_FROM_ACC_VALID && !FULL_TO_ACC; a write while full is dropped and sets overflow.
  - A pop is every M_AXIS handshake in SEND.
  - data_count: +1 on write only, −1 on pop only, unchanged when both or neither occur.
  - FULL_TO_ACC = (data_count == 2^FIFO_AW).
  - FWFT: the head word is visible on the cycle after it is written.
- FSM states: IDLE, HDR, SEND.
- IDLE:
  - TVALID=0, busy=0.
  - On start_1trans=1: latch num_dma_symbol into len_r, hdr_en into hdr_r, and tsf_runtime_val into tsf_r; clear beat_cnt and overflow.
  - Go to HDR if hdr_en=1, else SEND. busy=1 from the next cycle.
- HDR:
  - TVALID=1, TDATA=tsf_r, TLAST=0.
  - On TREADY → SEND. No FIFO pop.
- SEND:
  - TVALID = FIFO not empty; TDATA = FIFO head; TLAST = TVALID && (beat_cnt == len_r).
  - Each handshake pops the FIFO and increments beat_cnt.
  - A handshake with TLAST=1 → IDLE; trans_done=1 for exactly the following cycle.
- start_1trans outside IDLE is ignored: no latch, no effect.
- Beats per transfer = len_r + 1 + hdr_r. len_r=0 yields a single data beat.
- beat_cnt is MAX_BIT_NUM_DMA_SYMBOL wide and never wraps, because the transfer ends at len_r.
- FIFO writes are accepted in every state, so data may be buffered before start.

## Timing
- Reset (asynchronous assert, synchronous release) clears: state=IDLE, TVALID=0, TLAST=0, TDATA=0, busy=0, trans_done=0, overflow=0, FIFO empty, data_count=0, FULL_TO_ACC=0.
- Reset mid-transfer aborts immediately. FIFO contents are discarded and no trans_done pulse is generated.
- Start latency: start_1trans at cycle N → TVALID may assert at N+1, for either the header beat or a FIFO word already present.
- Write-to-stream latency: a write at cycle N into an empty FIFO during SEND → TVALID=1 at N+1.
- AXIS rule: once TVALID=1, TVALID, TDATA and TLAST stay stable until TREADY=1.
- Throughput: one beat per cycle while the FIFO is non-empty and TREADY=1.
- Simultaneous write and pop while full: the write is dropped (full is evaluated before the pop), overflow is set, and data_count decrements.
- Simultaneous write and pop on a 1-entry FIFO: data_count stays 1 and TVALID stays 1.
- The last handshake at cycle N gives: busy=0 at N+1 and trans_done=1 at N+1. A new start is accepted at N+1.

## Test plan
- Basic transfer: preload 4 words 0x1..0x4, hdr_en=0, num=3, start, TREADY=1 → beats 0x1,0x2,0x3,0x4 on consecutive cycles with TLAST only on 0x4; trans_done one cycle later; data_count=0.
- Header: tsf_runtime_val=0xABCD at start, hdr_en=1, num=0, FIFO holds 0x55 → beats 0xABCD (TLAST=0) then 0x55 (TLAST=1).
- Backpressure: num=7, TREADY toggling 1/0 randomly, writes trickling in 1 per 3 cycles → 8 beats in order; TVALID/TDATA held while TREADY=0; no beat lost or duplicated.
- Overflow: FIFO_AW=6, write 65 words with no transfer armed → FULL_TO_ACC=1 at count 64, overflow=1, data_count=64; next start clears overflow; streaming num=63 drains exactly 64 words.
- Ignored start: pulse start_1trans during SEND with a different num → the original length is honoured and TLAST is asserted at the original count.
- Reset mid-transfer: assert ARESETN=0 after beat 2 of 8 → TVALID=0 and busy=0 immediately, data_count=0; after release, a new transfer of 2 words completes normally.
